// File: rtl/reg_bridge_pkg.sv
// rtl/reg_bridge_pkg.sv - register map, RAM FSM states and status bit positions for reg_bridge
package reg_bridge_pkg;

    localparam logic [5:0] A_CTRL    = 6'h00;
    localparam logic [5:0] A_ADDR0   = 6'h01;
    localparam logic [5:0] A_ADDR1   = 6'h02;
    localparam logic [5:0] A_ADDR2   = 6'h03;
    localparam logic [5:0] A_DATA0   = 6'h04;
    localparam logic [5:0] A_SEL     = 6'h10;
    localparam logic [5:0] A_POS_LO  = 6'h11;
    localparam logic [5:0] A_POS_HI  = 6'h12;
    localparam logic [5:0] A_STATUS  = 6'h13;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DATA = 2'd2;

    // 0x00 read layout
    localparam int B_IMG   = 0;
    localparam int B_IDLE  = 1;
    localparam int B_FLAG0 = 2;
    // 0x13 read layout
    localparam int B_RAM_IDLE = 0;
    localparam int B_OVERRUN  = 1;

endpackage

// File: rtl/reg_bridge_servo_bank.sv
// rtl/reg_bridge_servo_bank.sv - servo shadow array with commit strobe and readback
module reg_bridge_servo_bank #(
    parameter int SERVO_N = 18,
    parameter int SERVO_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit,
    input  logic [7:0]                 sel,
    input  logic [SERVO_W-1:0]         pos,
    output logic [SERVO_W-1:0]         rd_pos,
    output logic [$clog2(SERVO_N)-1:0] servo_select,
    output logic [SERVO_W-1:0]         servo_position,
    output logic                       servo_update
);

    localparam int SEL_W = $clog2(SERVO_N);
    localparam logic [7:0] N8 = 8'(SERVO_N);

    logic [SERVO_W-1:0] shadow [SERVO_N];
    logic               sel_ok;

    assign sel_ok = (sel < N8);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SERVO_N; i++) shadow[i] <= '0;
            servo_update   <= 1'b0;
            servo_select   <= '0;
            servo_position <= '0;
        end else begin
            servo_update <= 1'b0;
            // out-of-range selects are silently discarded, outputs keep last commit
            if (commit && sel_ok) begin
                for (int i = 0; i < SERVO_N; i++) begin
                    if (sel == 8'(i)) shadow[i] <= pos;
                end
                servo_update   <= 1'b1;
                servo_select   <= SEL_W'(sel);
                servo_position <= pos;
            end
        end
    end

    always_comb begin
        rd_pos = '0;
        for (int i = 0; i < SERVO_N; i++) begin
            if (sel == 8'(i)) rd_pos = shadow[i];
        end
    end

endmodule

// File: rtl/reg_bridge.sv
// rtl/reg_bridge.sv - byte-wide register bridge to SDRAM, servo bank, camera and sticky event flags
module reg_bridge
    import reg_bridge_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int DATA_BYTES = 4,
    parameter int SERVO_N    = 18,
    parameter int SERVO_W    = 16,
    parameter int FLAG_N     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 reg_addr,
    input  logic                       write,
    input  logic                       new_req,
    input  logic [7:0]                 write_value,
    output logic [7:0]                 read_value,
    output logic [ADDR_W-1:0]          addr,
    output logic                       rw,
    output logic [8*DATA_BYTES-1:0]    data_in,
    input  logic [8*DATA_BYTES-1:0]    data_out,
    input  logic                       busy,
    output logic                       in_valid,
    input  logic                       out_valid,
    input  logic                       image_captured,
    input  logic [FLAG_N-1:0]          events,
    output logic                       capture_image,
    output logic [$clog2(SERVO_N)-1:0] servo_select,
    output logic [SERVO_W-1:0]         servo_position,
    output logic                       servo_update,
    output logic [FLAG_N-1:0]          flags,
    output logic                       ram_idle
);

    localparam logic [5:0] A_DATA_TOP = 6'(A_DATA0 + 6'(DATA_BYTES - 1));

    logic [1:0]         state;
    logic [7:0]         hold_b [DATA_BYTES];
    logic [ADDR_W-1:0]  addr_r;
    logic               auto_inc;
    logic [FLAG_N-1:0]  sticky;
    logic               overrun;
    logic [7:0]         sel_r;
    logic [7:0]         pos_lo;
    logic [SERVO_W-1:0] rd_pos;
    logic [15:0]        rd16;
    logic [22:0]        addr_ext;
    logic [22:0]        addr_wr;
    logic [7:0]         rd_mux;

    logic rd_req, wr_req, fsm_idle, trig_wr, trig_rd, trig, accept;
    logic clr_flags, clr_overrun, commit;

    assign rd_req      = new_req & ~write;
    assign wr_req      = new_req & write;
    assign fsm_idle    = (state == ST_IDLE);
    assign trig_wr     = wr_req && (reg_addr == A_DATA_TOP);
    assign trig_rd     = rd_req && (reg_addr == A_DATA0);
    assign trig        = trig_wr | trig_rd;
    assign accept      = trig & fsm_idle;
    assign clr_flags   = rd_req && (reg_addr == A_CTRL);
    assign clr_overrun = rd_req && (reg_addr == A_STATUS);
    assign commit      = wr_req && (reg_addr == A_POS_HI);

    assign ram_idle = fsm_idle;
    assign addr     = addr_r;
    assign flags    = sticky;
    assign addr_ext = 23'(addr_r);
    assign rd16     = 16'(rd_pos);

    for (genvar g = 0; g < DATA_BYTES; g++) begin : g_data_in
        assign data_in[8*g +: 8] = hold_b[g];
    end

    // RAM request FSM; in_valid is a single-cycle strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            in_valid <= 1'b0;
            rw       <= 1'b0;
        end else begin
            in_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rw <= trig_wr;
                        if (!busy) begin
                            in_valid <= 1'b1;
                            state    <= trig_wr ? ST_IDLE : ST_WAIT_DATA;
                        end else begin
                            state <= ST_WAIT_BUSY;
                        end
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!busy) begin
                        in_valid <= 1'b1;
                        state    <= rw ? ST_IDLE : ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (out_valid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < DATA_BYTES; b++) hold_b[b] <= 8'h00;
        end else if (state == ST_WAIT_DATA && out_valid) begin
            for (int b = 0; b < DATA_BYTES; b++) hold_b[b] <= data_out[8*b +: 8];
        end else if (wr_req && fsm_idle) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (reg_addr == A_DATA0 + 6'(b)) hold_b[b] <= write_value;
            end
        end
    end

    always_comb begin
        addr_wr = addr_ext;
        case (reg_addr)
            A_ADDR0: addr_wr[7:0]   = write_value;
            A_ADDR1: addr_wr[15:8]  = write_value;
            A_ADDR2: addr_wr[22:16] = write_value[6:0];
            default: addr_wr = addr_ext;
        endcase
    end

    // host address writes take priority over the post-strobe increment
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= '0;
            auto_inc <= 1'b0;
        end else if (wr_req && fsm_idle &&
                     (reg_addr == A_ADDR0 || reg_addr == A_ADDR1 || reg_addr == A_ADDR2)) begin
            addr_r <= addr_wr[ADDR_W-1:0];
            if (reg_addr == A_ADDR2) auto_inc <= write_value[7];
        end else if (in_valid && auto_inc) begin
            addr_r <= addr_r + ADDR_W'(1);
        end
    end

    // set beats clear when an event and a clearing read coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky        <= '0;
            overrun       <= 1'b0;
            capture_image <= 1'b0;
            sel_r         <= 8'h00;
            pos_lo        <= 8'h00;
        end else begin
            sticky        <= (sticky & ~{FLAG_N{clr_flags}}) | events;
            overrun       <= (overrun & ~clr_overrun) | (trig & ~fsm_idle);
            capture_image <= wr_req && (reg_addr == A_CTRL) && write_value[0];
            if (wr_req && reg_addr == A_SEL)    sel_r  <= write_value;
            if (wr_req && reg_addr == A_POS_LO) pos_lo <= write_value;
        end
    end

    reg_bridge_servo_bank #(
        .SERVO_N (SERVO_N),
        .SERVO_W (SERVO_W)
    ) u_servo_bank (
        .clk            (clk),
        .rst            (rst),
        .commit         (commit),
        .sel            (sel_r),
        .pos            (SERVO_W'({write_value, pos_lo})),
        .rd_pos         (rd_pos),
        .servo_select   (servo_select),
        .servo_position (servo_position),
        .servo_update   (servo_update)
    );

    always_comb begin
        rd_mux = 8'h00;
        case (reg_addr)
            A_CTRL: begin
                rd_mux[B_IMG]              = image_captured;
                rd_mux[B_IDLE]             = fsm_idle;
                rd_mux[B_FLAG0 +: FLAG_N]  = sticky;
            end
            A_ADDR0:  rd_mux = addr_ext[7:0];
            A_ADDR1:  rd_mux = addr_ext[15:8];
            A_ADDR2:  rd_mux = {auto_inc, addr_ext[22:16]};
            A_SEL:    rd_mux = sel_r;
            A_POS_LO: rd_mux = rd16[7:0];
            A_POS_HI: rd_mux = rd16[15:8];
            A_STATUS: begin
                rd_mux[B_RAM_IDLE] = fsm_idle;
                rd_mux[B_OVERRUN]  = overrun;
            end
            default: begin
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (reg_addr == A_DATA0 + 6'(b)) rd_mux = hold_b[b];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)         read_value <= 8'h00;
        else if (rd_req) read_value <= rd_mux;
    end

endmodule

// File: tb/tb_reg_bridge.sv
// tb/tb_reg_bridge.sv - directed self-checking bench for reg_bridge
module tb_reg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  reg_addr;
    logic        write;
    logic        new_req;
    logic [7:0]  write_value;
    logic [7:0]  read_value;
    logic [22:0] addr;
    logic        rw;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        in_valid;
    logic        out_valid;
    logic        image_captured;
    logic [3:0]  events;
    logic        capture_image;
    logic [4:0]  servo_select;
    logic [15:0] servo_position;
    logic        servo_update;
    logic [3:0]  flags;
    logic        ram_idle;

    int total = 0;
    int bad = 0;
    int iv_cnt = 0;
    logic [7:0] v;
    logic seen;

    always #5 clk = ~clk;

    always @(negedge clk) if (in_valid === 1'b1) iv_cnt++;

    reg_bridge dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .write(write), .new_req(new_req),
        .write_value(write_value), .read_value(read_value), .addr(addr), .rw(rw),
        .data_in(data_in), .data_out(data_out), .busy(busy), .in_valid(in_valid),
        .out_valid(out_valid), .image_captured(image_captured), .events(events),
        .capture_image(capture_image), .servo_select(servo_select),
        .servo_position(servo_position), .servo_update(servo_update), .flags(flags),
        .ram_idle(ram_idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_addr = a; write = 1'b1; write_value = d; new_req = 1'b1;
        @(negedge clk);
        new_req = 1'b0; write = 1'b0;
    endtask

    task automatic reg_rd(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        reg_addr = a; write = 1'b0; new_req = 1'b1;
        @(negedge clk);
        new_req = 1'b0;
        d = read_value;
    endtask

    task automatic ram_return(input logic [31:0] d);
        @(negedge clk);
        data_out = d; out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; reg_addr = '0; write = 1'b0; new_req = 1'b0; write_value = '0;
        data_out = '0; busy = 1'b0; out_valid = 1'b0; image_captured = 1'b0; events = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_read_value", read_value, 8'h00);
        chk("rst_ram_idle", ram_idle, 1'b1);
        chk("rst_outputs", {in_valid, rw, capture_image, servo_update, flags, addr}, '0);
        chk("rst_data_in", data_in, 32'h0);

        // auto-increment write burst
        reg_wr(6'h03, 8'h80);
        reg_wr(6'h01, 8'h10);
        reg_wr(6'h04, 8'h11);
        reg_wr(6'h05, 8'h22);
        reg_wr(6'h06, 8'h33);
        iv_cnt = 0;
        reg_wr(6'h07, 8'h44);
        chk("wr_in_valid", in_valid, 1'b1);
        chk("wr_rw", rw, 1'b1);
        chk("wr_addr", addr, 23'h10);
        chk("wr_data_in", data_in, 32'h44332211);
        tick();
        chk("wr_addr_inc", addr, 23'h11);
        chk("wr_one_strobe", iv_cnt, 1);

        // busy holds the request back
        busy = 1'b1;
        reg_wr(6'h07, 8'h55);
        chk("busy_ram_idle", ram_idle, 1'b0);
        seen = in_valid;
        repeat (4) begin
            tick();
            seen = seen | in_valid;
        end
        chk("busy_no_strobe", seen, 1'b0);
        busy = 1'b0;
        tick();
        chk("busy_strobe", in_valid, 1'b1);
        chk("busy_addr_stable", addr, 23'h11);
        chk("busy_data_in", data_in, 32'h55332211);
        tick();
        chk("busy_after_strobe", {ram_idle, in_valid, addr}, {1'b1, 1'b0, 23'h12});

        // RAM read with overrun during WAIT_DATA
        iv_cnt = 0;
        reg_rd(6'h04, v);
        chk("rd_byte0_now", v, 8'h11);
        chk("rd_strobe", {in_valid, rw, ram_idle}, 3'b100);
        reg_wr(6'h07, 8'h99);
        chk("drop_hold_write", data_in, 32'h55332211);
        reg_rd(6'h13, v);
        chk("status_overrun", v, 8'h02);
        reg_rd(6'h04, v);
        chk("rd_byte0_busy", v, 8'h11);
        ram_return(32'hDEADBEEF);
        chk("rd_loaded", data_in, 32'hDEADBEEF);
        chk("rd_idle_again", ram_idle, 1'b1);
        chk("rd_one_strobe", iv_cnt, 1);
        reg_rd(6'h13, v);
        chk("status_after_ret", v, 8'h03);
        reg_rd(6'h13, v);
        chk("status_cleared", v, 8'h01);
        reg_rd(6'h07, v);
        chk("rd_byte3", v, 8'hDE);
        reg_rd(6'h06, v);
        chk("rd_byte2", v, 8'hAD);
        ram_return(32'hFFFFFFFF);
        chk("idle_out_valid_ignored", data_in, 32'hDEADBEEF);
        reg_rd(6'h04, v);
        chk("rd_byte0", v, 8'hEF);
        @(negedge clk);
        reg_addr = 6'h05; write = 1'b0; new_req = 1'b1;
        data_out = 32'h01020304; out_valid = 1'b1;
        @(negedge clk);
        new_req = 1'b0; out_valid = 1'b0;
        chk("same_cycle_old_byte", read_value, 8'hBE);
        chk("same_cycle_loaded", data_in, 32'h01020304);
        reg_rd(6'h0C, v);
        chk("unmapped_read", v, 8'h00);

        // servo bank
        reg_wr(6'h10, 8'd5);
        reg_wr(6'h11, 8'h34);
        reg_wr(6'h12, 8'h12);
        chk("servo_strobe", {servo_update, servo_select, servo_position}, {1'b1, 5'd5, 16'h1234});
        tick();
        chk("servo_hold", {servo_update, servo_select, servo_position}, {1'b0, 5'd5, 16'h1234});
        reg_rd(6'h11, v);
        chk("servo_rd_lo", v, 8'h34);
        reg_rd(6'h12, v);
        chk("servo_rd_hi", v, 8'h12);
        reg_wr(6'h10, 8'd18);
        reg_wr(6'h11, 8'h78);
        reg_wr(6'h12, 8'h56);
        chk("servo_bad_sel", {servo_update, servo_select, servo_position}, {1'b0, 5'd5, 16'h1234});
        reg_rd(6'h11, v);
        chk("servo_bad_sel_rd", v, 8'h00);

        // sticky flags and capture
        @(negedge clk);
        reg_addr = 6'h00; write = 1'b0; new_req = 1'b1; events = 4'b0100;
        @(negedge clk);
        new_req = 1'b0; events = 4'b0000;
        chk("flag_clear_race_rd", read_value, 8'h02);
        chk("flag_kept", flags, 4'b0100);
        reg_rd(6'h00, v);
        chk("flag_read", v, 8'h12);
        chk("flag_cleared", flags, 4'b0000);
        image_captured = 1'b1;
        reg_rd(6'h00, v);
        chk("image_bit", v, 8'h03);
        image_captured = 1'b0;
        reg_wr(6'h00, 8'h01);
        chk("capture_pulse", capture_image, 1'b1);
        tick();
        chk("capture_end", capture_image, 1'b0);

        // address wrap
        reg_wr(6'h01, 8'hFF);
        reg_wr(6'h02, 8'hFF);
        reg_wr(6'h03, 8'hFF);
        reg_rd(6'h03, v);
        chk("addr_hi_rd", v, 8'hFF);
        reg_wr(6'h07, 8'hAA);
        chk("wrap_strobe_addr", {in_valid, addr}, {1'b1, 23'h7FFFFF});
        tick();
        chk("wrap_addr", addr, 23'h0);

        // reset mid-transaction
        reg_rd(6'h04, v);
        chk("mid_wait_data", ram_idle, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ram_return(32'h12345678);
        chk("mid_rst_ignored", {ram_idle, data_in}, {1'b1, 32'h0});
        busy = 1'b1;
        reg_wr(6'h07, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        busy = 1'b0;
        iv_cnt = 0;
        repeat (3) tick();
        chk("mid_rst_no_strobe", iv_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
